dct_2d_sched: RTL and testbench

//  Sequencer for the shared 1-D DCT kernel (one_D_DCT_kernal) that computes an 8x8 2-D DCT.
//  - Buffers an 8x8 input block, arriving one row per handshake.
//  - Drives the kernel's CNT and A_0..A_7 for a row pass, then for a column pass.
//  - Transposes the row-pass results between the passes.
//  - Streams the 8 column-pass result rows to the downstream quantiser.

---
 rtl/dct_pkg.sv | 20 ++
 rtl/dct_transpose_buf.sv | 34 +++
 rtl/dct_2d_sched.sv | 159 +++++++++++++++
 tb/tb_dct_2d_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants, FSM encoding and packed-row slicing helper for the 2-D DCT sequencer.
package dct_pkg;

    localparam int N          = 8;
    localparam int EXECYCLE   = 12;
    localparam int KERNEL_LAT = 5;
    localparam int PASS_LEN   = EXECYCLE + 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2
    } state_t;

    // Low bit offset of sample idx inside a packed row of w-bit samples.
    function automatic int row_sel(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/dct_transpose_buf.sv
// 8x8 transpose store between the row pass and the column pass.
// Written one column per cycle from the kernel outputs, read one row per cycle.
module dct_transpose_buf #(
    parameter int DATA_W = 16
) (
    input  logic                Clk,
    input  logic                wr_en,
    input  logic [2:0]          wr_col,
    input  logic [8*DATA_W-1:0] wr_data,
    input  logic [2:0]          rd_row,
    output logic [8*DATA_W-1:0] rd_data
);
    import dct_pkg::*;

    logic signed [DATA_W-1:0] t_buf [N][N];

    // Column write: kernel output B_j lands in row j of the selected column.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int j = 0; j < N; j++) begin
                t_buf[j][wr_col] <= wr_data[row_sel(j, DATA_W) +: DATA_W];
            end
        end
    end

    // Row read: repack one stored row for the kernel A inputs.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < N; j++) begin
            rd_data[row_sel(j, DATA_W) +: DATA_W] = t_buf[rd_row][j];
        end
    end

endmodule

// File: rtl/dct_2d_sched.sv
// Sequencer that runs the shared 1-D DCT kernel twice (rows, then transposed columns)
// to produce an 8x8 2-D DCT, overlapping the next block's load with the column pass.
// Optional build macro DCT_SCHED_STATS_EN adds blk_cnt (completed blocks) and ovf_err
// (sticky: a row was offered while the row pass was running).
module dct_2d_sched #(
    parameter int DATA_W     = 16,
    parameter int EXECYCLE   = dct_pkg::EXECYCLE,
    parameter int KERNEL_LAT = dct_pkg::KERNEL_LAT
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*DATA_W-1:0] in_row,
    output logic [8:0]          kern_cnt,
    output logic [8*DATA_W-1:0] kern_a,
    input  logic [8*DATA_W-1:0] kern_b,
    output logic                out_valid,
    output logic [8*DATA_W-1:0] out_row,
    output logic [2:0]          out_idx,
    output logic                out_last
`ifdef DCT_SCHED_STATS_EN
    ,
    output logic [15:0]         blk_cnt,
    output logic                ovf_err
`endif
);
    import dct_pkg::*;

    localparam logic [8:0] CNT_LAST = 9'(EXECYCLE);
    localparam logic [8:0] CNT_LAT  = 9'(KERNEL_LAT);

    state_t              state;
    logic [3:0]          ld_cnt;
    logic [3:0]          ld_next;
    logic                accept;
    logic                pass_end;
    logic                a_win;
    logic [8:0]          b_off;
    logic                b_win;
    logic [2:0]          b_idx;
    logic [8*DATA_W-1:0] t_row;
    logic [8*DATA_W-1:0] in_buf [N];

    // Result row r appears on kern_b KERNEL_LAT cycles after its A was presented;
    // below the latency the subtraction wraps high, so one compare bounds the window.
    assign b_off    = kern_cnt - CNT_LAT;
    assign b_win    = (b_off < 9'd8);
    assign b_idx    = b_off[2:0];
    assign a_win    = (kern_cnt < 9'd8);
    assign pass_end = (kern_cnt == CNT_LAST);

    assign in_ready = !Rst && (state == LOAD || state == COL) && !ld_cnt[3];
    assign accept   = in_valid && in_ready;
    assign ld_next  = accept ? ld_cnt + 4'd1 : ld_cnt;

    // Input row buffer: accepted rows are stored by arrival order.
    always_ff @(posedge Clk) begin
        if (accept) begin
            in_buf[ld_cnt[2:0]] <= in_row;
        end
    end

    dct_transpose_buf #(.DATA_W(DATA_W)) u_tbuf (
        .Clk     (Clk),
        .wr_en   (state == ROW && b_win),
        .wr_col  (b_idx),
        .wr_data (kern_b),
        .rd_row  (kern_cnt[2:0]),
        .rd_data (t_row)
    );

    // Kernel A mux: input rows during the row pass, transposed rows during the column pass.
    always_comb begin
        kern_a = '0;
        if (a_win) begin
            if (state == ROW) begin
                kern_a = in_buf[kern_cnt[2:0]];
            end else if (state == COL) begin
                kern_a = t_row;
            end
        end
    end

    // Pass sequencing, load counting and registered output control.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= LOAD;
            ld_cnt    <= 4'd0;
            kern_cnt  <= 9'd0;
            out_valid <= 1'b0;
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ld_cnt    <= ld_next;
            case (state)
                LOAD: begin
                    kern_cnt <= 9'd0;
                    if (ld_cnt[3]) begin
                        state <= ROW;
                    end
                end
                ROW: begin
                    if (pass_end) begin
                        state    <= COL;
                        kern_cnt <= 9'd0;
                        ld_cnt   <= 4'd0;
                    end else begin
                        kern_cnt <= kern_cnt + 9'd1;
                    end
                end
                COL: begin
                    if (b_win) begin
                        out_valid <= 1'b1;
                        out_idx   <= b_idx;
                        out_last  <= (b_idx == 3'd7);
                    end
                    if (pass_end) begin
                        kern_cnt <= 9'd0;
                        state    <= ld_next[3] ? ROW : LOAD;
                    end else begin
                        kern_cnt <= kern_cnt + 9'd1;
                    end
                end
                default: begin
                    state    <= LOAD;
                    kern_cnt <= 9'd0;
                end
            endcase
        end
    end

    // Output data row: captured alongside out_valid, no reset on the data path.
    always_ff @(posedge Clk) begin
        if (state == COL && b_win) begin
            out_row <= kern_b;
        end
    end

`ifdef DCT_SCHED_STATS_EN
    // Block counter and sticky overflow flag.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            blk_cnt <= 16'd0;
            ovf_err <= 1'b0;
        end else begin
            if (state == COL && b_win && b_idx == 3'd7) begin
                blk_cnt <= blk_cnt + 16'd1;
            end
            if (state == ROW && in_valid && !in_ready) begin
                ovf_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dct_2d_sched.sv
// Bench for dct_2d_sched with a behavioural 5-cycle-latency 1-D DCT kernel.
// Build with DCT_SCHED_STATS_EN defined to also cover blk_cnt / ovf_err.
module tb_dct_2d_sched;

    localparam int DATA_W = 16;
    localparam int W      = 8 * DATA_W;

    // Integer DCT-II basis scaled by 32 (DC row by 64/sqrt(8)); kernel output is >>> 6.
    localparam int COEF [8][8] = '{
        '{23,  23,  23,  23,  23,  23,  23,  23},
        '{31,  27,  18,   6,  -6, -18, -27, -31},
        '{30,  12, -12, -30, -30, -12,  12,  30},
        '{27,  -6, -31, -18,  18,  31,   6, -27},
        '{23, -23, -23,  23,  23, -23, -23,  23},
        '{18, -31,   6,  27, -27,  -6,  31, -18},
        '{12, -30,  30, -12, -12,  30, -30,  12},
        '{ 6, -18,  27, -31,  31, -27,  18,  -6}
    };

    typedef struct {
        logic [W-1:0] row;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_row = '0;
    logic [8:0]   kern_cnt;
    logic [W-1:0] kern_a;
    logic [W-1:0] kern_b;
    logic         out_valid;
    logic [W-1:0] out_row;
    logic [2:0]   out_idx;
    logic         out_last;
`ifdef DCT_SCHED_STATS_EN
    logic [15:0]  blk_cnt;
    logic         ovf_err;
`endif

    dct_2d_sched #(.DATA_W(DATA_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .kern_cnt  (kern_cnt),
        .kern_a    (kern_a),
        .kern_b    (kern_b),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef DCT_SCHED_STATS_EN
        ,
        .blk_cnt   (blk_cnt),
        .ovf_err   (ovf_err)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // 1-D kernel function: B_j = (sum_i C[j][i] * A_i) >>> 6, truncated to DATA_W.
    function automatic logic [W-1:0] kern1d(input logic [W-1:0] a);
        logic [W-1:0] b;
        int acc;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            acc = 0;
            for (int i = 0; i < 8; i++) begin
                acc += COEF[j][i] * int'($signed(a[i*DATA_W +: DATA_W]));
            end
            acc = acc >>> 6;
            b[j*DATA_W +: DATA_W] = acc[DATA_W-1:0];
        end
        return b;
    endfunction

    // Kernel pipeline: A sampled at CNT=k shows on B at CNT=k+5.
    logic [W-1:0] kpipe [5];
    always @(posedge Clk) begin
        kpipe[0] <= kern1d(kern_a);
        for (int i = 1; i < 5; i++) kpipe[i] <= kpipe[i-1];
    end
    assign kern_b = kpipe[4];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq [$];
    logic [W-1:0] blk [8];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every out_valid.
    int           ov_seen = 0;
    int           t_first = -1;
    int           t_last [$];
    logic [W-1:0] row0_seen = '0;
    exp_t         mon_e;
    always @(negedge Clk) begin
        if (out_valid) begin
            ov_seen++;
            if (out_idx == 3'd0) begin
                t_first   = cyc;
                row0_seen = out_row;
            end
            if (out_last) t_last.push_back(cyc);
            chk("out_expected", W'(sbq.size() > 0), W'(1));
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("out_row", out_row, mon_e.row);
                chk("out_idx", W'(out_idx), W'(mon_e.idx));
                chk("out_last", W'(out_last), W'(mon_e.last));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Row pass, transpose, column pass, written as plain matrix steps.
    task automatic push_expected();
        logic [W-1:0] b;
        logic [W-1:0] t [8];
        exp_t e;
        for (int r = 0; r < 8; r++) t[r] = '0;
        for (int k = 0; k < 8; k++) begin
            b = kern1d(blk[k]);
            for (int j = 0; j < 8; j++) t[j][k*DATA_W +: DATA_W] = b[j*DATA_W +: DATA_W];
        end
        for (int r = 0; r < 8; r++) begin
            e.row  = kern1d(t[r]);
            e.idx  = 3'(r);
            e.last = (r == 7);
            sbq.push_back(e);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                blk[k][j*DATA_W +: DATA_W] = 16'($urandom_range(0, 511)) - 16'd256;
    endtask

    task automatic send_row(input logic [W-1:0] r, output int t_acc);
        int g;
        bit acc;
        g   = 0;
        acc = 0;
        in_valid = 1'b1;
        in_row   = r;
        do begin
            @(negedge Clk);
            acc = in_ready;
            tick();
            g++;
        end while (!acc && g < 100);
        chk("row_accept", W'(acc), W'(1));
        t_acc = cyc;
    endtask

    // Sends blk; returns the edge number of the 8th accept. in_valid dropped unless hold.
    task automatic send_block(input bit gaps, input bit hold, output int t8);
        int g;
        for (int k = 0; k < 8; k++) begin
            g = 0;
            while (gaps && $urandom_range(0, 1) == 1 && g < 4) begin
                in_valid = 1'b0;
                tick();
                g++;
            end
            send_row(blk[k], t8);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sbq.size() > 0 && g < 200) begin
            tick();
            g++;
        end
        chk("drain", W'(sbq.size()), W'(0));
        repeat (3) tick();
    endtask

    int t8;
    int ov_before;
    int g5;

    initial begin
        // Reset state.
        repeat (3) tick();
        @(negedge Clk);
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_kern_cnt", W'(kern_cnt), W'(0));
        chk("rst_out_idx", W'(out_idx), W'(0));
        chk("rst_out_last", W'(out_last), W'(0));
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("idle_in_ready", W'(in_ready), W'(1));
        tick();

        // DC block, in_valid held across rows.
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) blk[k][j*DATA_W +: DATA_W] = 16'd64;
        push_expected();
        ov_before = ov_seen;
        send_block(1'b0, 1'b0, t8);
        wait_drain();
        chk("dc_row0", row0_seen, W'(529));
        chk("dc_first_valid_t", W'(t_first), W'(t8 + 20));
        chk("dc_last_t", W'(t_last[$]), W'(t8 + 27));
        chk("dc_valid_count", W'(ov_seen - ov_before), W'(8));

        // Impulse block.
        for (int k = 0; k < 8; k++) blk[k] = '0;
        blk[0][DATA_W-1:0] = 16'd1024;
        push_expected();
        send_block(1'b0, 1'b0, t8);
        wait_drain();

        // Random gaps while loading; ROW begins one cycle after the 8th accept.
        fill_rand();
        push_expected();
        send_block(1'b1, 1'b0, t8);
        @(negedge Clk);
        chk("gap_ready_full", W'(in_ready), W'(0));
        chk("gap_load_kern_a", kern_a, W'(0));
        tick();
        @(negedge Clk);
        chk("gap_row_cnt0", W'(kern_cnt), W'(0));
        chk("gap_row_a0", kern_a, blk[0]);
        tick();
        @(negedge Clk);
        chk("gap_row_cnt1", W'(kern_cnt), W'(1));
        chk("gap_row_a1", kern_a, blk[1]);
        wait_drain();

        // Two blocks, the second loaded during the first one's column pass.
        fill_rand();
        push_expected();
        send_block(1'b0, 1'b1, t8);
        fill_rand();
        push_expected();
        send_block(1'b0, 1'b0, t8);
        wait_drain();
        chk("b2b_last_count", W'(t_last.size() >= 2), W'(1));
        if (t_last.size() >= 2)
            chk("b2b_last_spacing", W'(t_last[$] - t_last[$-1]), W'(26));

        // Reset during the row pass at kern_cnt=6, then a fresh block.
        fill_rand();
        send_block(1'b0, 1'b0, t8);
        g5 = 0;
        while (kern_cnt != 9'd6 && g5 < 50) begin
            tick();
            g5++;
        end
        chk("abort_reach_cnt6", W'(kern_cnt), W'(6));
        Rst = 1'b1;
        tick();
        @(negedge Clk);
        chk("abort_kern_cnt", W'(kern_cnt), W'(0));
        chk("abort_in_ready", W'(in_ready), W'(0));
        chk("abort_out_valid", W'(out_valid), W'(0));
        tick();
        Rst = 1'b0;
        ov_before = ov_seen;
        repeat (40) tick();
        chk("abort_no_output", W'(ov_seen - ov_before), W'(0));
`ifdef DCT_SCHED_STATS_EN
        chk("stats_rst_blk_cnt", W'(blk_cnt), W'(0));
        chk("stats_rst_ovf", W'(ovf_err), W'(0));
`endif
        fill_rand();
        push_expected();
        send_block(1'b0, 1'b0, t8);
        wait_drain();
`ifdef DCT_SCHED_STATS_EN
        chk("stats_blk_cnt1", W'(blk_cnt), W'(1));
        chk("stats_ovf_quiet", W'(ovf_err), W'(0));

        // in_valid held high into the row pass.
        fill_rand();
        push_expected();
        send_block(1'b0, 1'b1, t8);
        repeat (4) tick();
        in_valid = 1'b0;
        @(negedge Clk);
        chk("stats_ovf_set", W'(ovf_err), W'(1));
        wait_drain();
        chk("stats_blk_cnt2", W'(blk_cnt), W'(2));
        chk("stats_ovf_sticky", W'(ovf_err), W'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
